// File: rtl/vproc_pkg.sv
// Shared types for the vector configuration unit: CFG operation encoding,
// vtype/vxrm field enums and the CFG sequencing FSM states.
package vproc_pkg;

    typedef enum logic [1:0] {
        VSEW_8       = 2'd0,
        VSEW_16      = 2'd1,
        VSEW_32      = 2'd2,
        VSEW_INVALID = 2'd3
    } cfg_vsew;

    // vlmul encoding as held in vtype (fractional settings in the upper half)
    typedef enum logic [2:0] {
        LMUL_1       = 3'd0,
        LMUL_2       = 3'd1,
        LMUL_4       = 3'd2,
        LMUL_8       = 3'd3,
        LMUL_INVALID = 3'd4,
        LMUL_F8      = 3'd5,
        LMUL_F4      = 3'd6,
        LMUL_F2      = 3'd7
    } cfg_lmul;

    typedef enum logic [1:0] {
        VXRM_RNU = 2'd0,
        VXRM_RNE = 2'd1,
        VXRM_RDN = 2'd2,
        VXRM_ROD = 2'd3
    } cfg_vxrm;

    typedef enum logic [3:0] {
        CFG_VSETVL       = 4'd0,
        CFG_VTYPE_READ   = 4'd1,
        CFG_VL_READ      = 4'd2,
        CFG_VLENB_READ   = 4'd3,
        CFG_VSTART_WRITE = 4'd4,
        CFG_VSTART_SET   = 4'd5,
        CFG_VSTART_CLEAR = 4'd6,
        CFG_VXSAT_WRITE  = 4'd7,
        CFG_VXSAT_SET    = 4'd8,
        CFG_VXSAT_CLEAR  = 4'd9,
        CFG_VXRM_WRITE   = 4'd10,
        CFG_VXRM_SET     = 4'd11,
        CFG_VXRM_CLEAR   = 4'd12,
        CFG_VCSR_WRITE   = 4'd13,
        CFG_VCSR_SET     = 4'd14,
        CFG_VCSR_CLEAR   = 4'd15
    } cfg_csr_op;

    typedef struct packed {
        cfg_csr_op  csr_op;
        cfg_vsew    vsew;
        cfg_lmul    lmul;
        logic [1:0] agnostic;
        logic       vlmax;
        logic       keep_vl;
    } op_mode_cfg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RESP  = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/vproc_cfg_vlmax.sv
// Combinational VLMAX and vtype legality for a requested SEW/LMUL pair
// (ELEN fixed at 32).
module vproc_cfg_vlmax
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W = 128
) (
    input  cfg_vsew                   vsew,
    input  cfg_lmul                   lmul,
    output logic [$clog2(VREG_W):0]   vlmax,
    output logic                      illegal
);

    localparam int unsigned VL_W = $clog2(VREG_W) + 1;
    localparam logic [VL_W-1:0] VLMAX_E8_M1 = VL_W'(VREG_W / 8);

    logic [VL_W-1:0] vlmax_m1;

    always_comb begin
        vlmax_m1 = VLMAX_E8_M1 >> 2'(vsew);
        case (lmul)
            LMUL_2:  vlmax = vlmax_m1 << 1;
            LMUL_4:  vlmax = vlmax_m1 << 2;
            LMUL_8:  vlmax = vlmax_m1 << 3;
            LMUL_F2: vlmax = vlmax_m1 >> 1;
            LMUL_F4: vlmax = vlmax_m1 >> 2;
            LMUL_F8: vlmax = vlmax_m1 >> 3;
            default: vlmax = vlmax_m1;
        endcase
    end

    // fractional LMUL is only legal while SEW <= ELEN*LMUL
    always_comb begin
        illegal = (vsew == VSEW_INVALID)
                | (lmul == LMUL_INVALID)
                | (lmul == LMUL_F8)
                | ((lmul == LMUL_F4) && (vsew != VSEW_8))
                | ((lmul == LMUL_F2) && (vsew == VSEW_32));
    end

endmodule

// File: rtl/vproc_cfg_unit.sv
// Vector configuration unit: serialises vsetvl and vector CSR accesses,
// waiting for the pipeline to drain before committing any state change.
module vproc_cfg_unit
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W = 128
) (
    input  logic                          clk_i,
    input  logic                          sync_rst_i,
    input  logic                          op_valid_i,
    output logic                          op_ready_o,
    input  op_mode_cfg                    op_mode_i,
    input  logic [31:0]                   rs1_i,
    input  logic                          pipe_idle_i,
    input  logic                          vxsat_set_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [31:0]                   result_o,
    output cfg_vsew                       vsew_o,
    output cfg_lmul                       lmul_o,
    output logic [1:0]                    agnostic_o,
    output logic                          vill_o,
    output logic [$clog2(VREG_W):0]       vl_o,
    output logic                          vl_0_o,
    output cfg_vxrm                       vxrm_o,
    output logic                          vxsat_o,
    output logic [$clog2(VREG_W)-1:0]     vstart_o
);

    localparam int unsigned VL_W     = $clog2(VREG_W) + 1;
    localparam int unsigned VSTART_W = $clog2(VREG_W);

    cfg_state_e            state_q, state_d;
    op_mode_cfg            op_q, op_d;
    logic [31:0]           rs1_q, rs1_d;
    logic                  op_ready_q, op_ready_d;
    logic                  result_valid_q, result_valid_d;
    logic [31:0]           result_q, result_d;
    cfg_vsew               vsew_q, vsew_d;
    cfg_lmul               lmul_q, lmul_d;
    logic [1:0]            agnostic_q, agnostic_d;
    logic                  vill_q, vill_d;
    logic [VL_W-1:0]       vl_q, vl_d;
    logic                  vl_0_q, vl_0_d;
    cfg_vxrm               vxrm_q, vxrm_d;
    logic                  vxsat_q, vxsat_d;
    logic [VSTART_W-1:0]   vstart_q, vstart_d;

    logic                  commit;
    logic [2:0]            vcsr_new;
    logic [VL_W-1:0]       vlmax;
    logic                  illegal;

    vproc_cfg_vlmax #(
        .VREG_W (VREG_W)
    ) u_vlmax (
        .vsew    (op_q.vsew),
        .lmul    (op_q.lmul),
        .vlmax   (vlmax),
        .illegal (illegal)
    );

    // next state, commit of the captured operation and output next values
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs1_d      = rs1_q;
        result_d   = result_q;
        vsew_d     = vsew_q;
        lmul_d     = lmul_q;
        agnostic_d = agnostic_q;
        vill_d     = vill_q;
        vl_d       = vl_q;
        vxrm_d     = vxrm_q;
        vxsat_d    = vxsat_q | vxsat_set_i;
        vstart_d   = vstart_q;
        vcsr_new   = '0;
        commit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    state_d = DRAIN;
                    op_d    = op_mode_i;
                    rs1_d   = rs1_i;
                end
            end
            DRAIN: begin
                if (pipe_idle_i) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            case (op_q.csr_op)
                CFG_VSETVL: begin
                    vsew_d     = op_q.vsew;
                    lmul_d     = op_q.lmul;
                    agnostic_d = op_q.agnostic;
                    vill_d     = illegal;
                    vstart_d   = '0;
                    if (illegal) begin
                        vl_d = '0;
                    end else if (op_q.vlmax) begin
                        vl_d = vlmax;
                    end else if (op_q.keep_vl) begin
                        vl_d = (vl_q < vlmax) ? vl_q : vlmax;
                    end else begin
                        vl_d = (rs1_q < 32'(vlmax)) ? VL_W'(rs1_q) : vlmax;
                    end
                    result_d = 32'(vl_d);
                end
                CFG_VTYPE_READ: result_d = {vill_q, 23'b0, agnostic_q[1], agnostic_q[0],
                                            1'b0, vsew_q, lmul_q};
                CFG_VL_READ:    result_d = 32'(vl_q);
                CFG_VLENB_READ: result_d = 32'(VREG_W / 8);
                CFG_VSTART_WRITE, CFG_VSTART_SET, CFG_VSTART_CLEAR: begin
                    result_d = 32'(vstart_q);
                    if (op_q.csr_op == CFG_VSTART_WRITE)    vstart_d = rs1_q[VSTART_W-1:0];
                    else if (op_q.csr_op == CFG_VSTART_SET) vstart_d = vstart_q | rs1_q[VSTART_W-1:0];
                    else                                    vstart_d = vstart_q & ~rs1_q[VSTART_W-1:0];
                end
                // explicit write/clear of vxsat overrides a same-cycle set request
                CFG_VXSAT_WRITE: begin
                    result_d = 32'(vxsat_q);
                    vxsat_d  = rs1_q[0];
                end
                CFG_VXSAT_SET: begin
                    result_d = 32'(vxsat_q);
                    vxsat_d  = vxsat_q | rs1_q[0] | vxsat_set_i;
                end
                CFG_VXSAT_CLEAR: begin
                    result_d = 32'(vxsat_q);
                    vxsat_d  = vxsat_q & ~rs1_q[0];
                end
                CFG_VXRM_WRITE, CFG_VXRM_SET, CFG_VXRM_CLEAR: begin
                    result_d = 32'(vxrm_q);
                    if (op_q.csr_op == CFG_VXRM_WRITE)    vxrm_d = cfg_vxrm'(rs1_q[1:0]);
                    else if (op_q.csr_op == CFG_VXRM_SET) vxrm_d = cfg_vxrm'(vxrm_q | rs1_q[1:0]);
                    else                                  vxrm_d = cfg_vxrm'(vxrm_q & ~rs1_q[1:0]);
                end
                CFG_VCSR_WRITE, CFG_VCSR_SET, CFG_VCSR_CLEAR: begin
                    result_d = 32'({vxrm_q, vxsat_q});
                    if (op_q.csr_op == CFG_VCSR_WRITE)    vcsr_new = rs1_q[2:0];
                    else if (op_q.csr_op == CFG_VCSR_SET) vcsr_new = {vxrm_q, vxsat_q} | rs1_q[2:0];
                    else                                  vcsr_new = {vxrm_q, vxsat_q} & ~rs1_q[2:0];
                    vxrm_d  = cfg_vxrm'(vcsr_new[2:1]);
                    vxsat_d = (op_q.csr_op == CFG_VCSR_SET) ? (vcsr_new[0] | vxsat_set_i)
                                                            : vcsr_new[0];
                end
                default: ;
            endcase
        end

        vl_0_d         = (vl_d == '0);
        result_valid_d = (state_d == RESP);
        op_ready_d     = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q        <= IDLE;
            op_q           <= '0;
            rs1_q          <= '0;
            op_ready_q     <= 1'b1;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            vsew_q         <= VSEW_8;
            lmul_q         <= LMUL_1;
            agnostic_q     <= '0;
            vill_q         <= 1'b1;
            vl_q           <= '0;
            vl_0_q         <= 1'b1;
            vxrm_q         <= VXRM_RNU;
            vxsat_q        <= 1'b0;
            vstart_q       <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            rs1_q          <= rs1_d;
            op_ready_q     <= op_ready_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            vsew_q         <= vsew_d;
            lmul_q         <= lmul_d;
            agnostic_q     <= agnostic_d;
            vill_q         <= vill_d;
            vl_q           <= vl_d;
            vl_0_q         <= vl_0_d;
            vxrm_q         <= vxrm_d;
            vxsat_q        <= vxsat_d;
            vstart_q       <= vstart_d;
        end
    end

    assign op_ready_o     = op_ready_q;
    assign result_valid_o = result_valid_q;
    assign result_o       = result_q;
    assign vsew_o         = vsew_q;
    assign lmul_o         = lmul_q;
    assign agnostic_o     = agnostic_q;
    assign vill_o         = vill_q;
    assign vl_o           = vl_q;
    assign vl_0_o         = vl_0_q;
    assign vxrm_o         = vxrm_q;
    assign vxsat_o        = vxsat_q;
    assign vstart_o       = vstart_q;

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Bench for vproc_cfg_unit (VREG_W=128): directed scenarios followed by random
// operations, checked against an arithmetic model of vtype/vl/CSR semantics.
module tb_vproc_cfg_unit;
    import vproc_pkg::*;

    localparam int unsigned VLEN = 128;

    logic        clk_i;
    logic        sync_rst_i;
    logic        op_valid_i;
    logic        op_ready_o;
    op_mode_cfg  op_mode_i;
    logic [31:0] rs1_i;
    logic        pipe_idle_i;
    logic        vxsat_set_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_o;
    cfg_vsew     vsew_o;
    cfg_lmul     lmul_o;
    logic [1:0]  agnostic_o;
    logic        vill_o;
    logic [7:0]  vl_o;
    logic        vl_0_o;
    cfg_vxrm     vxrm_o;
    logic        vxsat_o;
    logic [6:0]  vstart_o;

    vproc_cfg_unit #(.VREG_W(VLEN)) dut (
        .clk_i          (clk_i),
        .sync_rst_i     (sync_rst_i),
        .op_valid_i     (op_valid_i),
        .op_ready_o     (op_ready_o),
        .op_mode_i      (op_mode_i),
        .rs1_i          (rs1_i),
        .pipe_idle_i    (pipe_idle_i),
        .vxsat_set_i    (vxsat_set_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .vsew_o         (vsew_o),
        .lmul_o         (lmul_o),
        .agnostic_o     (agnostic_o),
        .vill_o         (vill_o),
        .vl_o           (vl_o),
        .vl_0_o         (vl_0_o),
        .vxrm_o         (vxrm_o),
        .vxsat_o        (vxsat_o),
        .vstart_o       (vstart_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    // architectural model state
    int m_vsew, m_lmul, m_agn, m_vill, m_vl, m_vxrm, m_vxsat, m_vstart, m_result;
    op_mode_cfg  p_op;
    logic [31:0] p_rs1;
    logic [31:0] last_result;
    bit          rand_set_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_vsew = 0; m_lmul = 0; m_agn = 0; m_vill = 1; m_vl = 0;
        m_vxrm = 0; m_vxsat = 0; m_vstart = 0; m_result = 0;
    endfunction

    // returns the written-back value and applies the architectural effect
    function automatic int model_commit(input op_mode_cfg op, input logic [31:0] rs1, input logic s);
        int sew, num, den, code, vlmax, res, old, nv;
        bit ill;
        longint unsigned r;
        r = rs1;
        res = 0;
        case (op.csr_op)
            CFG_VSETVL: begin
                sew  = 8 << int'(op.vsew);
                code = int'(op.lmul);
                if (code < 4) begin num = 1 << code; den = 1; end
                else          begin num = 1; den = (code == 4) ? 1 : (1 << (8 - code)); end
                ill   = (int'(op.vsew) == 3) || (code == 4) || (sew * den > 32 * num);
                vlmax = (VLEN * num) / (sew * den);
                m_vsew = int'(op.vsew); m_lmul = code; m_agn = int'(op.agnostic);
                m_vill = ill;
                if (ill)             m_vl = 0;
                else if (op.vlmax)   m_vl = vlmax;
                else if (op.keep_vl) m_vl = (m_vl < vlmax) ? m_vl : vlmax;
                else                 m_vl = (r < longint'(vlmax)) ? int'(r) : vlmax;
                m_vstart = 0;
                m_vxsat |= s;
                res = m_vl;
            end
            CFG_VTYPE_READ: begin
                res = (m_vill << 31) | (m_agn << 6) | (m_vsew << 3) | m_lmul;
                m_vxsat |= s;
            end
            CFG_VL_READ:    begin res = m_vl;     m_vxsat |= s; end
            CFG_VLENB_READ: begin res = VLEN / 8; m_vxsat |= s; end
            CFG_VSTART_WRITE: begin res = m_vstart; m_vstart = int'(rs1 % 128);              m_vxsat |= s; end
            CFG_VSTART_SET:   begin res = m_vstart; m_vstart = (m_vstart | int'(rs1 % 128)); m_vxsat |= s; end
            CFG_VSTART_CLEAR: begin res = m_vstart; m_vstart = m_vstart & ~int'(rs1 % 128);  m_vxsat |= s; end
            CFG_VXSAT_WRITE:  begin res = m_vxsat; m_vxsat = int'(rs1 % 2); end
            CFG_VXSAT_SET:    begin res = m_vxsat; m_vxsat = m_vxsat | int'(rs1 % 2) | s; end
            CFG_VXSAT_CLEAR:  begin res = m_vxsat; m_vxsat = (rs1 % 2 == 1) ? 0 : m_vxsat; end
            CFG_VXRM_WRITE:   begin res = m_vxrm; m_vxrm = int'(rs1 % 4);          m_vxsat |= s; end
            CFG_VXRM_SET:     begin res = m_vxrm; m_vxrm = m_vxrm | int'(rs1 % 4); m_vxsat |= s; end
            CFG_VXRM_CLEAR:   begin res = m_vxrm; m_vxrm = m_vxrm & ~int'(rs1 % 4); m_vxsat |= s; end
            default: begin
                old = m_vxrm * 2 + m_vxsat;
                if (op.csr_op == CFG_VCSR_WRITE)    nv = int'(rs1 % 8);
                else if (op.csr_op == CFG_VCSR_SET) nv = old | int'(rs1 % 8);
                else                                nv = old & ~int'(rs1 % 8);
                res = old;
                m_vxrm  = (nv >> 1) & 3;
                m_vxsat = (nv & 1) | ((op.csr_op == CFG_VCSR_SET) ? int'(s) : 0);
            end
        endcase
        return res;
    endfunction

    // advances one clock; the model follows the same edge
    task automatic step(input bit commit_now);
        logic s;
        if (rand_set_en && !commit_now) vxsat_set_i = ($urandom_range(0, 4) == 0);
        s = vxsat_set_i;
        @(posedge clk_i);
        if (sync_rst_i)      model_reset();
        else if (commit_now) m_result = model_commit(p_op, p_rs1, s);
        else                 m_vxsat |= s;
        if (!rand_set_en) vxsat_set_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".vsew"},   32'(vsew_o),     32'(m_vsew));
        chk({tag, ".lmul"},   32'(lmul_o),     32'(m_lmul));
        chk({tag, ".agn"},    32'(agnostic_o), 32'(m_agn));
        chk({tag, ".vill"},   32'(vill_o),     32'(m_vill));
        chk({tag, ".vl"},     32'(vl_o),       32'(m_vl));
        chk({tag, ".vl_0"},   32'(vl_0_o),     32'(m_vl == 0));
        chk({tag, ".vxrm"},   32'(vxrm_o),     32'(m_vxrm));
        chk({tag, ".vxsat"},  32'(vxsat_o),    32'(m_vxsat));
        chk({tag, ".vstart"}, 32'(vstart_o),   32'(m_vstart));
    endtask

    function automatic op_mode_cfg mk(input cfg_csr_op o, input cfg_vsew s, input cfg_lmul l,
                                      input logic [1:0] a, input logic vm, input logic kv);
        op_mode_cfg m;
        m.csr_op = o; m.vsew = s; m.lmul = l; m.agnostic = a; m.vlmax = vm; m.keep_vl = kv;
        return m;
    endfunction

    // one full transaction: accept, drain wait, commit, optional response stall
    task automatic run_op(input string tag, input op_mode_cfg m, input logic [31:0] rs1,
                          input int drain_wait, input int stall, input logic set_c);
        chk({tag, ".ready_idle"}, 32'(op_ready_o), 32'd1);
        op_valid_i = 1'b1; op_mode_i = m; rs1_i = rs1;
        p_op = m; p_rs1 = rs1;
        pipe_idle_i = 1'($urandom_range(0, 1));
        step(1'b0);
        op_valid_i = 1'b0; rs1_i = $urandom; op_mode_i = op_mode_cfg'(15'($urandom));
        chk({tag, ".ready_busy"}, 32'(op_ready_o), 32'd0);
        chk({tag, ".valid_drain"}, 32'(result_valid_o), 32'd0);
        for (int i = 0; i < drain_wait; i++) begin
            pipe_idle_i = 1'b0;
            step(1'b0);
            chk({tag, ".valid_wait"}, 32'(result_valid_o), 32'd0);
            check_state({tag, ".wait"});
        end
        pipe_idle_i = 1'b1;
        vxsat_set_i = set_c;
        step(1'b1);
        last_result = result_o;
        chk({tag, ".valid_resp"}, 32'(result_valid_o), 32'd1);
        chk({tag, ".result"}, result_o, 32'(m_result));
        check_state({tag, ".commit"});
        for (int i = 0; i < stall; i++) begin
            result_ready_i = 1'b0;
            step(1'b0);
            chk({tag, ".valid_stall"}, 32'(result_valid_o), 32'd1);
            chk({tag, ".result_stall"}, result_o, 32'(m_result));
        end
        result_ready_i = 1'b1;
        step(1'b0);
        result_ready_i = 1'b0;
        chk({tag, ".valid_done"}, 32'(result_valid_o), 32'd0);
        chk({tag, ".ready_done"}, 32'(op_ready_o), 32'd1);
    endtask

    initial begin
        op_mode_cfg m;
        logic [31:0] r;
        sync_rst_i = 1'b1; op_valid_i = 1'b0; op_mode_i = '0; rs1_i = '0;
        pipe_idle_i = 1'b1; vxsat_set_i = 1'b0; result_ready_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        step(1'b0);
        step(1'b0);
        sync_rst_i = 1'b0;
        chk("reset.valid", 32'(result_valid_o), 32'd0);
        chk("reset.result", result_o, 32'd0);
        chk("reset.vl_lit", 32'(vl_o), 32'd0);
        chk("reset.vill_lit", 32'(vill_o), 32'd1);
        check_state("reset");

        run_op("e32m2", mk(CFG_VSETVL, VSEW_32, LMUL_2, 2'b00, 1'b0, 1'b0), 32'd100, 0, 0, 1'b0);
        chk("e32m2.vl_lit", 32'(vl_o), 32'd8);
        run_op("vstart_w", mk(CFG_VSTART_WRITE, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd9, 0, 0, 1'b0);
        run_op("e16m4_max", mk(CFG_VSETVL, VSEW_16, LMUL_4, 2'b01, 1'b1, 1'b0), 32'd3, 0, 0, 1'b0);
        chk("e16m4.vl_lit", 32'(vl_o), 32'd32);
        run_op("vstart_trunc", mk(CFG_VSTART_WRITE, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd200, 0, 0, 1'b0);
        run_op("e8m1", mk(CFG_VSETVL, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd5, 0, 0, 1'b0);
        chk("e8m1.vl_lit", 32'(vl_o), 32'd5);
        chk("e8m1.vstart_lit", 32'(vstart_o), 32'd0);
        run_op("e8m8_big", mk(CFG_VSETVL, VSEW_8, LMUL_8, 2'b10, 1'b0, 1'b0), 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("e8m8_hi", mk(CFG_VSETVL, VSEW_8, LMUL_8, 2'b10, 1'b0, 1'b0), 32'h8000_0003, 0, 0, 1'b0);
        chk("e8m8_hi.vl_lit", 32'(vl_o), 32'd128);
        run_op("keep_vl", mk(CFG_VSETVL, VSEW_32, LMUL_1, 2'b00, 1'b0, 1'b1), 32'd77, 0, 0, 1'b0);
        run_op("e16f2", mk(CFG_VSETVL, VSEW_16, LMUL_F2, 2'b11, 1'b1, 1'b0), 32'd0, 1, 0, 1'b0);
        run_op("vtype_f2", mk(CFG_VTYPE_READ, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd0, 0, 0, 1'b0);
        run_op("e16f4", mk(CFG_VSETVL, VSEW_16, LMUL_F4, 2'b00, 1'b0, 1'b0), 32'd10, 0, 0, 1'b0);
        chk("e16f4.vill_lit", 32'(vill_o), 32'd1);
        chk("e16f4.vl0_lit", 32'(vl_0_o), 32'd1);
        run_op("vtype_f4", mk(CFG_VTYPE_READ, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd0, 0, 0, 1'b0);
        chk("vtype_f4.lit", last_result, 32'h8000_000E);
        run_op("vl_read", mk(CFG_VL_READ, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd0, 0, 0, 1'b0);
        run_op("vlenb", mk(CFG_VLENB_READ, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd0, 0, 0, 1'b0);
        chk("vlenb.lit", last_result, 32'd16);

        run_op("vcsr_w7", mk(CFG_VCSR_WRITE, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd7, 0, 0, 1'b0);
        chk("vcsr_w7.res_lit", last_result, 32'd0);
        run_op("vcsr_w5", mk(CFG_VCSR_WRITE, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd5, 0, 0, 1'b0);
        chk("vcsr_w5.vxrm_lit", 32'(vxrm_o), 32'(VXRM_RDN));
        run_op("vxrm_clr", mk(CFG_VXRM_CLEAR, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd2, 0, 0, 1'b0);
        chk("vxrm_clr.res_lit", last_result, 32'd2);
        chk("vxrm_clr.vxrm_lit", 32'(vxrm_o), 32'(VXRM_RNU));
        run_op("vxsat_clr", mk(CFG_VXSAT_CLEAR, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0), 32'd1, 0, 0, 1'b1);
        chk("vxsat_clr.lit", 32'(vxsat_o), 32'd0);

        run_op("drain_stall", mk(CFG_VSETVL, VSEW_8, LMUL_4, 2'b00, 1'b0, 1'b0), 32'd50, 3, 2, 1'b0);
        chk("drain_stall.vl_lit", 32'(vl_o), 32'd50);

        // reset while the vsetvl is waiting in DRAIN
        op_valid_i = 1'b1; op_mode_i = mk(CFG_VSETVL, VSEW_8, LMUL_1, 2'b00, 1'b0, 1'b0); rs1_i = 32'd4;
        pipe_idle_i = 1'b0;
        step(1'b0);
        op_valid_i = 1'b0;
        chk("rst_drain.valid0", 32'(result_valid_o), 32'd0);
        sync_rst_i = 1'b1; pipe_idle_i = 1'b1;
        step(1'b0);
        sync_rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_drain.valid", 32'(result_valid_o), 32'd0);
            step(1'b0);
        end
        chk("rst_drain.ready", 32'(op_ready_o), 32'd1);
        chk("rst_drain.vl_lit", 32'(vl_o), 32'd0);
        chk("rst_drain.vill_lit", 32'(vill_o), 32'd1);
        check_state("rst_drain");

        rand_set_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            m.csr_op   = cfg_csr_op'(4'($urandom_range(0, 15)));
            m.vsew     = cfg_vsew'(2'($urandom_range(0, 3)));
            m.lmul     = cfg_lmul'(3'($urandom_range(0, 7)));
            m.agnostic = 2'($urandom_range(0, 3));
            m.vlmax    = ($urandom_range(0, 3) == 0);
            m.keep_vl  = ($urandom_range(0, 3) == 0);
            if (n % 4 == 0) m.csr_op = CFG_VSETVL;
            r = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 140)) : $urandom;
            run_op("rand", m, r, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
        end
        rand_set_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
